// File: rtl/led_ctrl_pkg.sv
// Shared constants, mode encoding and small helpers for the LED blink sequencer.
package led_ctrl_pkg;

  // Blink modes; code 3 is never produced and is treated as OFF if ever seen.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2
  } mode_t;

  // Board defaults for a 100 MHz-class clock.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_SLOW_DIV        = 25_000_000;
  localparam int DEF_FAST_DIV        = 6_250_000;

  // Number of bits needed to hold values 0..maxVal (at least one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  // Press sequence OFF -> SLOW -> FAST -> OFF; anything unexpected lands on OFF.
  function automatic mode_t nextMode(input mode_t cur);
    case (cur)
      MODE_OFF:  return MODE_SLOW;
      MODE_SLOW: return MODE_FAST;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/toggle_rate_controller_if.sv
// Button-in / strobe-out bundle between the board pin, the sequencer and the toggler.
interface toggle_rate_controller_if;
  logic       ButtonIn;
  logic       ToggleEnable;
  logic       PressPulse;
  logic [1:0] Mode;

  // Side that owns the button and consumes the strobes.
  modport master (output ButtonIn, input ToggleEnable, input PressPulse, input Mode);
  // The sequencer itself.
  modport slave  (input ButtonIn, output ToggleEnable, output PressPulse, output Mode);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counting debouncer and press (rising-edge) pulse generator.
module button_debouncer
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic ButtonIn,
  output logic PressPulse
);

  localparam int              DW    = cntWidth(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]   DLAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] dcount;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ButtonIn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; pulse once when the accepted level rises.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stable     <= 1'b0;
      dcount     <= '0;
      PressPulse <= 1'b0;
    end else begin
      PressPulse <= 1'b0;
      if (sync2 == stable) begin
        dcount <= '0;
      end else if (dcount == DLAST) begin
        stable     <= sync2;
        dcount     <= '0;
        PressPulse <= sync2;
      end else begin
        dcount <= dcount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/toggle_rate_controller.sv
// Blink-rate sequencer: each clean button press steps OFF/SLOW/FAST, and the
// prescaler emits single-cycle ToggleEnable strobes at the selected rate.
module toggle_rate_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SLOW_DIV        = DEF_SLOW_DIV,
  parameter int FAST_DIV        = DEF_FAST_DIV
) (
  input  logic                      Clk,
  input  logic                      Rst,
  toggle_rate_controller_if.slave   bus
);

  localparam int            PW        = cntWidth(SLOW_DIV - 1);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

  logic          pressPulse;
  mode_t         modeState;
  logic [PW-1:0] pcount;
  logic          toggleEnable;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebouncer (
    .Clk       (Clk),
    .Rst       (Rst),
    .ButtonIn  (bus.ButtonIn),
    .PressPulse(pressPulse)
  );

  // Mode FSM and prescaler together: a press always restarts the count and
  // suppresses any strobe that would have fallen on the same edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      modeState    <= MODE_OFF;
      pcount       <= '0;
      toggleEnable <= 1'b0;
    end else if (pressPulse) begin
      modeState    <= nextMode(modeState);
      pcount       <= '0;
      toggleEnable <= 1'b0;
    end else begin
      case (modeState)
        MODE_SLOW: begin
          if (pcount == SLOW_LAST) begin
            pcount       <= '0;
            toggleEnable <= 1'b1;
          end else begin
            pcount       <= pcount + 1'b1;
            toggleEnable <= 1'b0;
          end
        end
        MODE_FAST: begin
          if (pcount == FAST_LAST) begin
            pcount       <= '0;
            toggleEnable <= 1'b1;
          end else begin
            pcount       <= pcount + 1'b1;
            toggleEnable <= 1'b0;
          end
        end
        default: begin
          modeState    <= MODE_OFF;
          pcount       <= '0;
          toggleEnable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ToggleEnable = toggleEnable;
  assign bus.PressPulse   = pressPulse;
  assign bus.Mode         = modeState;

endmodule

// File: tb/tb_toggle_rate_controller.sv
// Scoreboard bench for toggle_rate_controller with DEBOUNCE_CYCLES=4, SLOW_DIV=8, FAST_DIV=3.
// Expected pulses are queued with the edge number after which they must be seen;
// a negedge monitor pops and compares whenever PressPulse or ToggleEnable is high.
module tb_toggle_rate_controller;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  toggle_rate_controller_if bus();

  toggle_rate_controller #(
    .DEBOUNCE_CYCLES(4),
    .SLOW_DIV       (8),
    .FAST_DIV       (3)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Number of rising edges so far; read on the falling edge it equals the edge just taken.
  int edgeCnt = 0;
  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int cyc;
    bit isPress;
    int mode;
  } ev_t;

  ev_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  function automatic void pushEv(input int cyc, input bit isPress, input int mode);
    ev_t e;
    e.cyc     = cyc;
    e.isPress = isPress;
    e.mode    = mode;
    expQ.push_back(e);
  endfunction

  // Strobes every div edges after the mode-change edge m, strictly before edge r.
  function automatic void pushStrobes(input int m, input int div, input int r, input int mode);
    for (int c = m + div; c < r; c += div) pushEv(c, 1'b0, mode);
  endfunction

  function automatic void checkVal(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, req, edgeCnt);
    end
  endfunction

  function automatic void checkPulse(input bit isPress);
    string nm;
    ev_t   e;
    nm = isPress ? "PressPulse" : "ToggleEnable";
    compared++;
    if (expQ.size() == 0 || expQ[0].cyc != edgeCnt || expQ[0].isPress != isPress) begin
      mismatched++;
      $display("FAIL %s_unexpected: pulse at edge %0d, next expected event at edge %0d",
               nm, edgeCnt, (expQ.size() == 0) ? -1 : expQ[0].cyc);
    end else begin
      e = expQ.pop_front();
      $display("ok %s at edge %0d, Mode %0d", nm, edgeCnt, bus.Mode);
      checkVal({nm, "_mode"}, int'(bus.Mode), e.mode);
    end
  endfunction

  // Monitor: flag overdue expectations, then match any pulse present this cycle.
  always @(negedge Clk) begin
    while (expQ.size() > 0 && expQ[0].cyc < edgeCnt) begin
      compared++;
      mismatched++;
      $display("FAIL missed_%s: no pulse seen, expected after edge %0d",
               expQ[0].isPress ? "PressPulse" : "ToggleEnable", expQ[0].cyc);
      void'(expQ.pop_front());
    end
    if (bus.PressPulse === 1'b1)   checkPulse(1'b1);
    if (bus.ToggleEnable === 1'b1) checkPulse(1'b0);
  end

  // Advance to the falling edge just before edge e, so a change made now is first sampled at e.
  task automatic goEdge(input int e);
    while (edgeCnt < e - 1) @(negedge Clk);
  endtask

  task automatic setBtn(input int e, input bit v);
    goEdge(e);
    bus.ButtonIn = v;
  endtask

  // Hold reset for n edges starting at edge startEdge; base returns the last reset edge.
  task automatic doReset(input int startEdge, input int n, input bit toggle, output int base);
    goEdge(startEdge);
    Rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (toggle) bus.ButtonIn = ~bus.ButtonIn;
      @(negedge Clk);
      checkVal("reset_ToggleEnable", int'(bus.ToggleEnable), 0);
      checkVal("reset_PressPulse", int'(bus.PressPulse), 0);
      checkVal("reset_Mode", int'(bus.Mode), 0);
    end
    Rst = 1'b0;
    if (toggle) bus.ButtonIn = 1'b0;
    base = edgeCnt;
  endtask

  initial begin
    int b;
    int b2;
    bus.ButtonIn = 1'b0;

    // Power-on reset with a toggling button.
    doReset(1, 3, 1'b1, b);

    // Clean press first sampled at b+10.
    pushEv(b + 15, 1'b1, 0);
    pushStrobes(b + 16, 8, b + 45, 1);
    setBtn(b + 10, 1'b1);
    doReset(b + 45, 3, 1'b1, b);

    // Bounces of 1, 2, 3 cycles, then steady high from b+19.
    pushEv(b + 24, 1'b1, 0);
    pushStrobes(b + 25, 8, b + 45, 1);
    setBtn(b + 10, 1'b1);
    setBtn(b + 11, 1'b0);
    setBtn(b + 12, 1'b1);
    setBtn(b + 14, 1'b0);
    setBtn(b + 15, 1'b1);
    setBtn(b + 18, 1'b0);
    setBtn(b + 19, 1'b1);
    doReset(b + 45, 3, 1'b1, b);

    // Three presses: SLOW, FAST, back to OFF.
    pushEv(b + 15, 1'b1, 0);
    pushStrobes(b + 16, 8, b + 36, 1);
    pushEv(b + 35, 1'b1, 1);
    pushStrobes(b + 36, 3, b + 56, 2);
    pushEv(b + 55, 1'b1, 2);
    setBtn(b + 10, 1'b1);
    setBtn(b + 20, 1'b0);
    setBtn(b + 30, 1'b1);
    setBtn(b + 40, 1'b0);
    checkVal("mode_cycle_fast", int'(bus.Mode), 2);
    setBtn(b + 50, 1'b1);
    setBtn(b + 60, 1'b0);
    goEdge(b + 81);
    checkVal("mode_cycle_off", int'(bus.Mode), 0);
    doReset(b + 81, 3, 1'b1, b);

    // Second press lands Mode change on the edge where pcount is 7 in SLOW.
    pushEv(b + 15, 1'b1, 0);
    pushStrobes(b + 16, 8, b + 32, 1);
    pushEv(b + 31, 1'b1, 1);
    pushStrobes(b + 32, 3, b + 45, 2);
    setBtn(b + 10, 1'b1);
    setBtn(b + 20, 1'b0);
    setBtn(b + 26, 1'b1);
    doReset(b + 45, 3, 1'b1, b);

    // Reset while dcount is 2, button kept held through and after reset.
    setBtn(b + 10, 1'b1);
    doReset(b + 14, 2, 1'b0, b2);
    pushEv(b2 + 6, 1'b1, 0);
    pushStrobes(b2 + 7, 8, b + 45, 1);
    doReset(b + 45, 3, 1'b1, b);

    repeat (5) @(negedge Clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: %0d expected pulses never seen, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d, expected completion", edgeCnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/toggle_rate_controller.md
# toggle_rate_controller

Sequencer that drives the `ToggleEnable` input of the LED toggler from a single raw push button. It synchronizes and debounces the button and turns each clean press into a one-cycle pulse. Each press advances a three-state blink-mode FSM. The block emits single-cycle `ToggleEnable` strobes at a mode-dependent rate. It sits between the board button pin and the toggler flop.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change; must be ≥2.
- `SLOW_DIV`, default 25_000_000: strobe period in cycles in SLOW mode; must be ≥`FAST_DIV`.
- `FAST_DIV`, default 6_250_000: strobe period in cycles in FAST mode; must be ≥2.
- `Clk`  in  1  system clock; all state updates on rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `ButtonIn`  in  1  raw, asynchronous, bouncing button level; high means pressed.
- `ToggleEnable`  out  1  registered single-cycle strobe to the toggler.
- `PressPulse`  out  1  registered single-cycle strobe per accepted press.
- `Mode`  out  2  current mode: 0=OFF, 1=SLOW, 2=FAST; 3 is never driven.

## Operation
- **Synchronizer:** two flops, `sync1` then `sync2`; both reset to 0.
- **Debouncer:**
  - `stable` resets to 0. `dcount` is wide enough for `DEBOUNCE_CYCLES-1`.
  - When `sync2 == stable`, `dcount` clears to 0.
  - When they differ and `dcount == DEBOUNCE_CYCLES-1`, `stable` takes `sync2` and `dcount` clears. Otherwise `dcount` increments.
- **PressPulse:** registered. Goes high on the same edge that `stable` goes 0→1; low on every other cycle. A release (1→0) produces no pulse.
- **Mode FSM:**
  - Advances on `PressPulse`: OFF→SLOW→FAST→OFF.
  - Reset state is OFF. Mode code 3 is unreachable and recovers to OFF on the next edge.
- **Prescaler:**
  - `pcount` is sized for `SLOW_DIV-1`.
  - In OFF, `pcount` is held at 0 and no strobes are produced.
  - In SLOW or FAST with divisor `DIV`: when `pcount == DIV-1`, `pcount`←0 and `ToggleEnable`←1; otherwise `pcount` increments and `ToggleEnable`←0.
- **Mode change:** on the edge where Mode updates, `pcount`←0 and `ToggleEnable`←0, whatever the prior count.
- **Reset values:** `ToggleEnable`=0, `PressPulse`=0, `Mode`=0, all counters 0.
- **Reset mid-operation:** all state returns to reset values on that edge. A button still held at reset release is accepted as a new press after the full debounce latency.

## Timing
- **Press latency:** edge E is the first edge sampling `ButtonIn`=1. `PressPulse` is high in the cycle after edge E+1+`DEBOUNCE_CYCLES`.
- **Mode latency:** Mode changes one edge after `PressPulse` (edge M = E+2+`DEBOUNCE_CYCLES`).
- **First strobe:** appears after edge M+`DIV`. Strobes then repeat every `DIV` cycles exactly, with no jitter.
- **Glitch rejection:** any excursion of `sync2` shorter than `DEBOUNCE_CYCLES` cycles clears `dcount` and produces no change.
- `ToggleEnable` and `PressPulse` are never high for two consecutive cycles.
- **Simultaneous press and strobe due:** the mode change wins. The strobe is suppressed and the count restarts.

## Structure
- Shared package `led_ctrl_pkg` holds:
  - mode encodings `MODE_OFF`, `MODE_SLOW`, `MODE_FAST`;
  - the 2-bit mode typedef;
  - default divisor and debounce constants.
- Sub-module `button_debouncer`: synchronizer, debouncer and rising-edge `PressPulse` generator, parameterized by `DEBOUNCE_CYCLES`. The top level holds the FSM and prescaler.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `SLOW_DIV`=8, `FAST_DIV`=3.
- **Reset:** `Rst` high 3 cycles with `ButtonIn` toggling every cycle → all outputs 0, Mode=0 throughout.
- **Clean press:** `ButtonIn` 0→1 sampled first at edge 10 → `PressPulse` high only after edge 15; Mode=1 after edge 16; `ToggleEnable` pulses after edges 24, 32, 40.
- **Bounce:** pulses of 1, 2 and 3 cycles separated by 1-cycle lows, then a steady high → exactly one `PressPulse`, timed from the start of the steady high.
- **Mode cycle:** three clean presses → Mode goes 1, 2, 0. FAST strobes are 3 cycles apart. No `ToggleEnable` while OFF.
- **Press at strobe edge:** press timed so Mode changes on the edge where `pcount`=7 in SLOW → no strobe on that edge; first FAST strobe 3 cycles later.
- **Mid-debounce reset:** `Rst` asserted with `dcount`=2 → no `PressPulse`. Button still held after release → `PressPulse` 4 debounce cycles plus 2 synchronizer cycles after reset deasserts.
